// File: rtl/freqdiv_monitor_pkg.sv
// Shared types and constants for the divided-clock monitor.
// This package is imported by the monitor top and its test collateral.
package freqdiv_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_e;

  // The error code reported is the first cause seen after a clear.
  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_PERIOD = 2'b01;
  localparam logic [1:0] ERR_DUTY   = 2'b10;
  localparam logic [1:0] ERR_STALL  = 2'b11;

endpackage

// File: rtl/freqdiv_sync_edge.sv
// Multi-flop synchronizer with a registered rising-edge detector.
// o_sync and o_rise are aligned, so o_rise marks the first cycle in which o_sync is high.
module freqdiv_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  assign o_sync = r_prev;
  assign o_rise = r_rise;

endmodule

// File: rtl/freqdiv_monitor.sv
// Measures period and high time of the divider output in system-clock cycles,
// checks them against the programmed divisor, and reports lock and sticky errors.
module freqdiv_monitor
  import freqdiv_monitor_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             en_i,
  input  logic [3:0]       n_i,
  input  logic             clk_div_i,
  input  logic             err_clr_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             meas_valid_o,
  output logic             lock_o,
  output logic             err_o,
  output logic [1:0]       err_code_o
);

  localparam int                MW        = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]     LOCK_C    = MW'(LOCK_COUNT);
  localparam logic [CNT_W+1:0]  DUTY_TOL  = (CNT_W+2)'(1);

  state_e           r_state;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic [MW-1:0]    r_match;
  logic [3:0]       r_n;
  logic             r_meas_valid;
  logic             r_lock;
  logic             r_err;
  logic [1:0]       r_err_code;

  logic             w_s;
  logic             w_rise;
  logic [CNT_W-1:0] w_per_inc;
  logic [CNT_W-1:0] w_hi_inc;
  logic [MW-1:0]    w_match_inc;
  logic [CNT_W+1:0] w_two_hi;
  logic [CNT_W+1:0] w_per_ext;
  logic [CNT_W+1:0] w_duty_diff;
  logic             w_period_ok;
  logic             w_good;
  logic             w_n_changed;
  logic             w_active;
  logic             w_meas;
  logic             w_stall;
  logic             w_err_new;
  logic [1:0]       w_err_code_new;

  freqdiv_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_n),
    .i_async (clk_div_i),
    .o_sync  (w_s),
    .o_rise  (w_rise)
  );

  assign w_per_inc   = (r_per_cnt == CNT_MAX) ? r_per_cnt : r_per_cnt + 1'b1;
  assign w_hi_inc    = (w_s && (r_hi_cnt != CNT_MAX)) ? r_hi_cnt + 1'b1 : r_hi_cnt;
  assign w_match_inc = (r_match == LOCK_C) ? r_match : r_match + 1'b1;

  // Duty check: twice the high time may differ from the period by at most one cycle.
  assign w_two_hi    = {1'b0, r_hi_cnt, 1'b0};
  assign w_per_ext   = {2'b00, r_per_cnt};
  assign w_duty_diff = (w_two_hi >= w_per_ext) ? (w_two_hi - w_per_ext) : (w_per_ext - w_two_hi);
  assign w_period_ok = (r_per_cnt == CNT_W'(n_i));
  assign w_good      = w_period_ok && (w_duty_diff <= DUTY_TOL);

  // A disable or divisor change overrides any measurement or stall in the same cycle.
  assign w_n_changed    = (r_state != IDLE) && (n_i != r_n);
  assign w_active       = en_i && !w_n_changed && (r_state != IDLE);
  assign w_meas         = w_active && (r_state == MEAS) && w_rise;
  assign w_stall        = w_active && !w_rise && (r_per_cnt >= TIMEOUT_C);
  assign w_err_new      = (w_meas && !w_good) || w_stall;
  assign w_err_code_new = w_stall ? ERR_STALL : (w_period_ok ? ERR_DUTY : ERR_PERIOD);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state      <= IDLE;
      r_per_cnt    <= '0;
      r_hi_cnt     <= '0;
      r_period     <= '0;
      r_high       <= '0;
      r_match      <= '0;
      r_n          <= '0;
      r_meas_valid <= 1'b0;
      r_lock       <= 1'b0;
    end else begin
      r_n          <= n_i;
      r_meas_valid <= 1'b0;
      if (!en_i || w_n_changed) begin
        r_state   <= en_i ? ARM : IDLE;
        r_per_cnt <= '0;
        r_hi_cnt  <= '0;
        r_match   <= '0;
        r_lock    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: r_state <= ARM;
          ARM: begin
            if (w_rise) begin
              r_state   <= MEAS;
              r_per_cnt <= CNT_W'(1);
              r_hi_cnt  <= CNT_W'(1);
            end else if (w_stall) begin
              r_per_cnt <= '0;
              r_hi_cnt  <= '0;
              r_match   <= '0;
              r_lock    <= 1'b0;
            end else begin
              r_per_cnt <= w_per_inc;
            end
          end
          MEAS: begin
            if (w_rise) begin
              r_period     <= r_per_cnt;
              r_high       <= r_hi_cnt;
              r_meas_valid <= 1'b1;
              r_per_cnt    <= CNT_W'(1);
              r_hi_cnt     <= CNT_W'(w_s);
              if (w_good) begin
                r_match <= w_match_inc;
                r_lock  <= (w_match_inc == LOCK_C);
              end else begin
                r_match <= '0;
                r_lock  <= 1'b0;
              end
            end else if (w_stall) begin
              r_state   <= ARM;
              r_per_cnt <= '0;
              r_hi_cnt  <= '0;
              r_match   <= '0;
              r_lock    <= 1'b0;
            end else begin
              r_per_cnt <= w_per_inc;
              r_hi_cnt  <= w_hi_inc;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Only the first cause is kept; a new error beats a simultaneous clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else if (w_err_new) begin
      r_err <= 1'b1;
      if (!r_err || err_clr_i) begin
        r_err_code <= w_err_code_new;
      end
    end else if (err_clr_i) begin
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end
  end

  assign period_o     = r_period;
  assign high_o       = r_high;
  assign meas_valid_o = r_meas_valid;
  assign lock_o       = r_lock;
  assign err_o        = r_err;
  assign err_code_o   = r_err_code;

endmodule

// File: tb/tb_freqdiv_monitor.sv
// Directed bench for freqdiv_monitor: a half-cycle divider model drives clk_div_i
// and each task checks its own scenario against hand-computed values.
module tb_freqdiv_monitor;

  logic       wb_clk_i;
  logic       wb_rst_n;
  logic       en_i;
  logic [3:0] n_i;
  logic       clk_div_i;
  logic       err_clr_i;
  logic [7:0] period_o;
  logic [7:0] high_o;
  logic       meas_valid_o;
  logic       lock_o;
  logic       err_o;
  logic [1:0] err_code_o;

  int passCnt  = 0;
  int totalCnt = 0;

  int divPerHalf  = 8;
  int divHighHalf = 4;
  int divHc       = 0;
  bit divRun      = 1'b0;
  bit divStatic   = 1'b0;

  freqdiv_monitor dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_n     (wb_rst_n),
    .en_i         (en_i),
    .n_i          (n_i),
    .clk_div_i    (clk_div_i),
    .err_clr_i    (err_clr_i),
    .period_o     (period_o),
    .high_o       (high_o),
    .meas_valid_o (meas_valid_o),
    .lock_o       (lock_o),
    .err_o        (err_o),
    .err_code_o   (err_code_o)
  );

  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  // Divider model counted in half system-clock cycles so odd ratios straddle both edges.
  always @(wb_clk_i) begin
    #1;
    if (divRun) begin
      clk_div_i = (divHc < divHighHalf);
      divHc     = (divHc + 1 >= divPerHalf) ? 0 : divHc + 1;
    end else begin
      clk_div_i = divStatic;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #3;
  endtask

  task automatic waitMeas(input int maxCyc, output bit seen, output int cyc);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < maxCyc) begin
      tick();
      cyc++;
      if (meas_valid_o) seen = 1'b1;
    end
  endtask

  // Waits until the model has just produced a rising edge so a new ratio starts cleanly.
  task automatic waitDivRise();
    int guard = 0;
    do begin
      tick();
      guard++;
    end while (!(divHc == 1 || divHc == 2) && guard < 60);
  endtask

  task automatic pulseClear();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst_n  = 1'b0;
    en_i      = 1'b0;
    n_i       = 4'd0;
    err_clr_i = 1'b0;
    repeat (3) tick();
    totalCnt++; if (period_o !== 8'd0) $display("[TB] FAIL reset_period: got %0d, expected 0", period_o); else passCnt++;
    totalCnt++; if (high_o !== 8'd0) $display("[TB] FAIL reset_high: got %0d, expected 0", high_o); else passCnt++;
    totalCnt++; if (meas_valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b, expected 0", meas_valid_o); else passCnt++;
    totalCnt++; if (lock_o !== 1'b0) $display("[TB] FAIL reset_lock: got %b, expected 0", lock_o); else passCnt++;
    totalCnt++; if (err_o !== 1'b0) $display("[TB] FAIL reset_err: got %b, expected 0", err_o); else passCnt++;
    totalCnt++; if (err_code_o !== 2'b00) $display("[TB] FAIL reset_code: got %b, expected 00", err_code_o); else passCnt++;
    wb_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_div4();
    bit seen;
    int cyc;
    n_i         = 4'd4;
    divPerHalf  = 8;
    divHighHalf = 4;
    divHc       = 0;
    divRun      = 1'b1;
    repeat (6) tick();
    en_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      waitMeas((k == 1) ? 40 : 12, seen, cyc);
      totalCnt++; if (!seen) $display("[TB] FAIL div4_pulse[%0d]: got no pulse, expected pulse", k); else passCnt++;
      if (k > 1) begin
        totalCnt++; if (cyc != 4) $display("[TB] FAIL div4_spacing[%0d]: got %0d, expected 4", k, cyc); else passCnt++;
      end
      totalCnt++; if (period_o !== 8'd4) $display("[TB] FAIL div4_period[%0d]: got %0d, expected 4", k, period_o); else passCnt++;
      totalCnt++; if (high_o !== 8'd2) $display("[TB] FAIL div4_high[%0d]: got %0d, expected 2", k, high_o); else passCnt++;
      totalCnt++; if (lock_o !== (k == 4)) $display("[TB] FAIL div4_lock[%0d]: got %b, expected %b", k, lock_o, (k == 4)); else passCnt++;
      totalCnt++; if (err_o !== 1'b0) $display("[TB] FAIL div4_err[%0d]: got %b, expected 0", k, err_o); else passCnt++;
    end
  endtask

  task automatic test_odd_divider();
    bit seen;
    int cyc;
    waitDivRise();
    n_i         = 4'd5;
    divPerHalf  = 10;
    divHighHalf = 5;
    tick();
    totalCnt++; if (lock_o !== 1'b0) $display("[TB] FAIL odd_lock_drop: got %b, expected 0", lock_o); else passCnt++;
    for (int k = 1; k <= 4; k++) begin
      waitMeas(30, seen, cyc);
      totalCnt++; if (!seen) $display("[TB] FAIL odd_pulse[%0d]: got no pulse, expected pulse", k); else passCnt++;
      totalCnt++; if (period_o !== 8'd5) $display("[TB] FAIL odd_period[%0d]: got %0d, expected 5", k, period_o); else passCnt++;
      totalCnt++; if (high_o !== 8'd2 && high_o !== 8'd3) $display("[TB] FAIL odd_high[%0d]: got %0d, expected 2 or 3", k, high_o); else passCnt++;
      totalCnt++; if (lock_o !== (k == 4)) $display("[TB] FAIL odd_lock[%0d]: got %b, expected %b", k, lock_o, (k == 4)); else passCnt++;
      totalCnt++; if (err_o !== 1'b0) $display("[TB] FAIL odd_err[%0d]: got %b, expected 0", k, err_o); else passCnt++;
    end
  endtask

  task automatic test_period_error();
    bit seen;
    int cyc;
    en_i = 1'b0;
    repeat (2) tick();
    n_i         = 4'd6;
    divPerHalf  = 14;
    divHighHalf = 7;
    divHc       = 0;
    repeat (6) tick();
    en_i = 1'b1;
    waitMeas(40, seen, cyc);
    totalCnt++; if (!seen) $display("[TB] FAIL perr_pulse: got no pulse, expected pulse"); else passCnt++;
    totalCnt++; if (period_o !== 8'd7) $display("[TB] FAIL perr_period: got %0d, expected 7", period_o); else passCnt++;
    totalCnt++; if (err_o !== 1'b1) $display("[TB] FAIL perr_err: got %b, expected 1", err_o); else passCnt++;
    totalCnt++; if (err_code_o !== 2'b01) $display("[TB] FAIL perr_code: got %b, expected 01", err_code_o); else passCnt++;
    totalCnt++; if (lock_o !== 1'b0) $display("[TB] FAIL perr_lock: got %b, expected 0", lock_o); else passCnt++;
    waitDivRise();
    divPerHalf  = 12;
    divHighHalf = 6;
    waitMeas(20, seen, cyc);
    pulseClear();
    totalCnt++; if (err_o !== 1'b0) $display("[TB] FAIL perr_clear_err: got %b, expected 0", err_o); else passCnt++;
    totalCnt++; if (err_code_o !== 2'b00) $display("[TB] FAIL perr_clear_code: got %b, expected 00", err_code_o); else passCnt++;
    for (int k = 1; k <= 4; k++) begin
      waitMeas(20, seen, cyc);
      totalCnt++; if (!seen) $display("[TB] FAIL perr_relock_pulse[%0d]: got no pulse, expected pulse", k); else passCnt++;
      totalCnt++; if (period_o !== 8'd6) $display("[TB] FAIL perr_relock_period[%0d]: got %0d, expected 6", k, period_o); else passCnt++;
      totalCnt++; if (lock_o !== (k == 4)) $display("[TB] FAIL perr_relock_lock[%0d]: got %b, expected %b", k, lock_o, (k == 4)); else passCnt++;
      totalCnt++; if (err_o !== 1'b0) $display("[TB] FAIL perr_relock_err[%0d]: got %b, expected 0", k, err_o); else passCnt++;
    end
  endtask

  // Enable is raised one edge before ARM; the counter reaches 64 after 65 edges, flag on edge 66.
  task automatic test_stall();
    int firstErr;
    bit sawMeas;
    for (int lvl = 1; lvl >= 0; lvl--) begin
      en_i      = 1'b0;
      divRun    = 1'b0;
      divStatic = (lvl == 1);
      n_i       = 4'd1;
      tick();
      pulseClear();
      repeat (5) tick();
      totalCnt++; if (err_o !== 1'b0) $display("[TB] FAIL stall%0d_pre_err: got %b, expected 0", lvl, err_o); else passCnt++;
      en_i     = 1'b1;
      firstErr = 0;
      sawMeas  = 1'b0;
      for (int i = 1; i <= 80; i++) begin
        tick();
        if (err_o && firstErr == 0) firstErr = i;
        if (meas_valid_o) sawMeas = 1'b1;
      end
      totalCnt++; if (firstErr != 66) $display("[TB] FAIL stall%0d_time: got %0d, expected 66", lvl, firstErr); else passCnt++;
      totalCnt++; if (err_code_o !== 2'b11) $display("[TB] FAIL stall%0d_code: got %b, expected 11", lvl, err_code_o); else passCnt++;
      totalCnt++; if (sawMeas !== 1'b0) $display("[TB] FAIL stall%0d_nomeas: got %b, expected 0", lvl, sawMeas); else passCnt++;
      totalCnt++; if (lock_o !== 1'b0) $display("[TB] FAIL stall%0d_lock: got %b, expected 0", lvl, lock_o); else passCnt++;
    end
  endtask

  task automatic test_retune();
    bit seen;
    int cyc;
    bit sawMeas;
    en_i = 1'b0;
    tick();
    pulseClear();
    n_i         = 4'd8;
    divPerHalf  = 16;
    divHighHalf = 8;
    divHc       = 0;
    divRun      = 1'b1;
    repeat (6) tick();
    en_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      waitMeas(60, seen, cyc);
      totalCnt++; if (period_o !== 8'd8) $display("[TB] FAIL retune8_period[%0d]: got %0d, expected 8", k, period_o); else passCnt++;
      totalCnt++; if (lock_o !== (k == 4)) $display("[TB] FAIL retune8_lock[%0d]: got %b, expected %b", k, lock_o, (k == 4)); else passCnt++;
    end
    waitDivRise();
    n_i         = 4'd3;
    divPerHalf  = 6;
    divHighHalf = 3;
    tick();
    totalCnt++; if (lock_o !== 1'b0) $display("[TB] FAIL retune_lock_drop: got %b, expected 0", lock_o); else passCnt++;
    totalCnt++; if (err_o !== 1'b0) $display("[TB] FAIL retune_no_err: got %b, expected 0", err_o); else passCnt++;
    for (int k = 1; k <= 4; k++) begin
      waitMeas(30, seen, cyc);
      totalCnt++; if (!seen) $display("[TB] FAIL retune3_pulse[%0d]: got no pulse, expected pulse", k); else passCnt++;
      totalCnt++; if (period_o !== 8'd3) $display("[TB] FAIL retune3_period[%0d]: got %0d, expected 3", k, period_o); else passCnt++;
      totalCnt++; if (lock_o !== (k == 4)) $display("[TB] FAIL retune3_lock[%0d]: got %b, expected %b", k, lock_o, (k == 4)); else passCnt++;
      totalCnt++; if (err_o !== 1'b0) $display("[TB] FAIL retune3_err[%0d]: got %b, expected 0", k, err_o); else passCnt++;
    end
    tick();
    en_i = 1'b0;
    tick();
    totalCnt++; if (lock_o !== 1'b0) $display("[TB] FAIL disable_lock: got %b, expected 0", lock_o); else passCnt++;
    totalCnt++; if (period_o !== 8'd3) $display("[TB] FAIL disable_period: got %0d, expected 3", period_o); else passCnt++;
    sawMeas = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (meas_valid_o) sawMeas = 1'b1;
    end
    totalCnt++; if (sawMeas !== 1'b0) $display("[TB] FAIL disable_nomeas: got %b, expected 0", sawMeas); else passCnt++;
  endtask

  task automatic test_async_reset();
    bit seen;
    int cyc;
    int guard;
    n_i         = 4'd4;
    divPerHalf  = 8;
    divHighHalf = 4;
    divHc       = 0;
    repeat (6) tick();
    en_i = 1'b1;
    for (int k = 1; k <= 4; k++) waitMeas(40, seen, cyc);
    totalCnt++; if (lock_o !== 1'b1) $display("[TB] FAIL areset_prelock: got %b, expected 1", lock_o); else passCnt++;
    tick();
    wb_rst_n = 1'b0;
    #1;
    totalCnt++; if (lock_o !== 1'b0) $display("[TB] FAIL areset_lock: got %b, expected 0", lock_o); else passCnt++;
    totalCnt++; if (period_o !== 8'd0) $display("[TB] FAIL areset_period: got %0d, expected 0", period_o); else passCnt++;
    totalCnt++; if (high_o !== 8'd0) $display("[TB] FAIL areset_high: got %0d, expected 0", high_o); else passCnt++;
    totalCnt++; if (meas_valid_o !== 1'b0) $display("[TB] FAIL areset_valid: got %b, expected 0", meas_valid_o); else passCnt++;
    totalCnt++; if (err_code_o !== 2'b00) $display("[TB] FAIL areset_code: got %b, expected 00", err_code_o); else passCnt++;
    repeat (3) tick();
    guard = 0;
    while (clk_div_i !== 1'b0 && guard < 20) begin
      tick();
      guard++;
    end
    wb_rst_n = 1'b1;
    waitMeas(40, seen, cyc);
    totalCnt++; if (!seen) $display("[TB] FAIL areset_first_pulse: got no pulse, expected pulse"); else passCnt++;
    totalCnt++; if (cyc < 5) $display("[TB] FAIL areset_full_period: got %0d cycles, expected at least 5", cyc); else passCnt++;
    totalCnt++; if (period_o !== 8'd4) $display("[TB] FAIL areset_period_after: got %0d, expected 4", period_o); else passCnt++;
    totalCnt++; if (high_o !== 8'd2) $display("[TB] FAIL areset_high_after: got %0d, expected 2", high_o); else passCnt++;
    totalCnt++; if (err_o !== 1'b0) $display("[TB] FAIL areset_err_after: got %b, expected 0", err_o); else passCnt++;
  endtask

  initial begin
    $display("[TB] freqdiv_monitor directed bench start");
    test_reset();
    test_div4();
    test_odd_divider();
    test_period_error();
    test_stall();
    test_retune();
    test_async_reset();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/freqdiv_monitor.md
Name: freqdiv_monitor

Overview:
Measures the divided clock produced by the frequency-divider stage. It counts period and high time in system-clock cycles, checks them against the programmed divisor, and reports lock, errors and per-period measurements. It sits directly downstream of the divider in the user project. Its outputs drive LA/GPIO observation and let firmware confirm that the divider is running at the requested ratio.

Parameters:
CNT_W, 8, width of period/high counters and result outputs
SYNC_STAGES, 2, flops in the input synchronizer for clk_div_i (min 2)
TIMEOUT, 64, cycles with no rising edge before stall is declared (< 2^CNT_W)
LOCK_COUNT, 4, consecutive good periods required to assert lock_o

Ports:
wb_clk_i  in  1  system clock; all logic on posedge
wb_rst_n  in  1  asynchronous active-low reset
en_i  in  1  divider enable (same signal that drives the divider)
n_i  in  4  programmed divisor
clk_div_i  in  1  divider output; may toggle on either clock edge, treated as asynchronous
err_clr_i  in  1  synchronous clear of sticky error
period_o  out  CNT_W  last measured period in cycles
high_o  out  CNT_W  last measured high time in cycles
meas_valid_o  out  1  one-cycle pulse when period_o/high_o update
lock_o  out  1  LOCK_COUNT consecutive good periods seen
err_o  out  1  sticky error flag
err_code_o  out  2  first error cause: 01 period mismatch, 10 duty, 11 stall

Behaviour:
- Reset: every output 0; FSM in IDLE; synchronizer, counters and match count 0.
- Synchronizer: clk_div_i passes through SYNC_STAGES flops, giving s. rise = s & ~s_prev.
- FSM states:
  - IDLE:
    - Counters held at 0; lock_o 0.
    - When en_i=1, go to ARM.
  - ARM:
    - Waits for the first rise; the first partial period is discarded.
    - On rise: go to MEAS, per_cnt=1, hi_cnt=1.
  - MEAS, every cycle:
    - per_cnt+1 (saturating at 2^CNT_W-1).
    - hi_cnt+1 if s=1.
  - MEAS, on rise:
    - Latch period_o=per_cnt and high_o=hi_cnt.
    - Pulse meas_valid_o in the next cycle, aligned with the updated outputs.
    - Restart per_cnt=1, hi_cnt=s.
- Period check, applied at each latch:
  - good = (per_cnt == n_i) and |2*hi_cnt - per_cnt| <= 1.
  - Arithmetic is done at CNT_W+2 bits, unsigned compare after absolute difference.
  - good: match count +1, saturating at LOCK_COUNT; lock_o=1 when it reaches LOCK_COUNT.
  - not good: match count 0, lock_o 0, err_o=1.
  - The code is 01 if the period is wrong, else 10.
- Stall: in ARM or MEAS, if per_cnt (ARM uses the same counter) reaches TIMEOUT without a rise:
  - err_o=1, err code 11, lock_o 0.
  - Go to ARM with counters cleared.
- Sticky error:
  - err_code_o records only the first error; later errors do not overwrite it while err_o=1.
  - err_clr_i=1 clears err_o and err_code_o.
  - If err_clr_i and a new error occur in the same cycle, the new error wins.
- en_i falls, from any state: go to IDLE next cycle, lock_o 0, match count 0. period_o/high_o/err keep their values.
- n_i changes while not IDLE (compare against a registered copy):
  - Go to ARM, lock_o 0, match count 0.
  - No error is raised, and any measurement completing in that cycle is discarded.
- n_i < 2: the divider output is static, so the block ends in the stall path (err code 11). This is the intended indication.
- Latency:
  - Raw edge to rise: SYNC_STAGES+1 cycles.
  - rise to meas_valid_o: 1 cycle.
  - lock_o asserts in the same cycle as the LOCK_COUNT-th good meas_valid_o.

Decomposition:
- Shared package: FSM state enum (IDLE, ARM, MEAS) and error-code constants ERR_NONE, ERR_PERIOD, ERR_DUTY, ERR_STALL.
- One sub-module, freqdiv_sync_edge: SYNC_STAGES synchronizer plus rising-edge detector, reused for other asynchronous monitor inputs.
- Counters, checker and FSM stay in the top module.

Test Plan:
- Divider modelled with n_i=4, en_i=1 → meas_valid_o pulses every 4 cycles with period_o=4, high_o=2; lock_o=1 on the 4th pulse; err_o stays 0.
- n_i=5, odd divider (high time spans both clock edges) → period_o=5, high_o 2 or 3; lock_o asserts; no duty error.
- Bench drives period 7 with n_i=6 → first meas_valid_o gives period_o=7, err_o=1, err_code_o=01, lock_o=0. Then pulse err_clr_i, drive a correct period-6 clock → err_o=0, lock_o returns after 4 periods.
- n_i=1 (output stuck high) → no meas_valid_o; 64 cycles after ARM, err_o=1, err_code_o=11. Same result with clk_div_i held at 0.
- Locked at n_i=8, then change n_i to 3 → lock_o drops next cycle, no error, relock at period 3. Deassert en_i mid-period → IDLE, lock_o=0, period_o keeps 3.
- Assert wb_rst_n=0 asynchronously mid-MEAS → all outputs 0 immediately, without waiting for a clock edge. After release, the first meas_valid_o occurs only after ARM sees a full period.
